// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
package lc3_mem_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_t;

    // A latency must fit the 4-bit countdown and be at least one edge.
    function automatic bit lat_ok(input int lat);
        return (lat >= 1) && (lat <= (1 << CNT_W) - 1);
    endfunction

endpackage

// File: rtl/lc3_mem_chan.sv
// One request channel: accept/busy FSM with a latency countdown.
// The acceptance edge counts as the first of LAT edges, so with LAT = 1
// the response is registered on the acceptance edge itself.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic accept,
    output logic respond,
    output logic complete,
    output logic err
);

    localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(LAT - 1);
    localparam bit               IMMEDIATE = (LAT == 1);

    if (!lat_ok(LAT)) begin : g_bad_lat
        $error("lc3_mem_chan: LAT must be in 1..15");
    end

    chan_state_t      state;
    chan_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             finish_busy;
    logic             err_nxt;

    // Acceptance, response timing and next-state selection.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        finish_busy = (state == BUSY) && (cnt == CNT_W'(1));
        accept      = req && ((state == IDLE) || finish_busy);
        respond     = finish_busy || (accept && IMMEDIATE);
        err_nxt     = err || (req && !accept);
        if (state == BUSY) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (finish_busy) begin
                state_nxt = IDLE;
            end
        end
        if (accept) begin
            cnt_nxt   = LAT_M1;
            state_nxt = IMMEDIATE ? IDLE : BUSY;
        end
    end

    // State, counter, completion pulse and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            complete <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            complete <= respond;
            err      <= err_nxt;
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 core: instruction and data memories
// with independent, configurable-latency request channels and a preload port.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INSTR_LAT = 1,
    parameter int DATA_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [WORD_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic [WORD_W-1:0] Data_addr,
    input  logic              data_req,
    input  logic              Data_rd,
    input  logic [WORD_W-1:0] Data_din,
    output logic [WORD_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              protocol_err
);

    localparam int DEPTH        = 1 << ADDR_W;
    localparam bit INSTR_DIRECT = (INSTR_LAT == 1);
    localparam bit DATA_DIRECT  = (DATA_LAT == 1);

    logic [WORD_W-1:0] imem [0:DEPTH-1];
    logic [WORD_W-1:0] dmem [0:DEPTH-1];

    logic [ADDR_W-1:0] instr_addr_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic              data_rd_q;
    logic [ADDR_W-1:0] instr_raddr;
    logic [ADDR_W-1:0] data_raddr;
    logic              data_rd_eff;

    logic instr_accept, instr_respond, instr_err;
    logic data_accept, data_respond, data_err;

    // Upper address bits alias onto the same words and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[WORD_W-1:ADDR_W], Data_addr[WORD_W-1:ADDR_W]};

    lc3_mem_chan #(.LAT(INSTR_LAT)) u_instr_chan (
        .clk      (clk),
        .reset    (reset),
        .req      (instrmem_rd),
        .accept   (instr_accept),
        .respond  (instr_respond),
        .complete (complete_instr),
        .err      (instr_err)
    );

    lc3_mem_chan #(.LAT(DATA_LAT)) u_data_chan (
        .clk      (clk),
        .reset    (reset),
        .req      (data_req),
        .accept   (data_accept),
        .respond  (data_respond),
        .complete (complete_data),
        .err      (data_err)
    );

    assign protocol_err = instr_err | data_err;

    // With single-edge latency the response uses the request as it is being accepted.
    assign instr_raddr = INSTR_DIRECT ? pc[ADDR_W-1:0] : instr_addr_q;
    assign data_raddr  = DATA_DIRECT ? Data_addr[ADDR_W-1:0] : data_addr_q;
    assign data_rd_eff = DATA_DIRECT ? Data_rd : data_rd_q;

    // Capture the request attributes of each accepted access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_addr_q <= '0;
            data_addr_q  <= '0;
            data_rd_q    <= 1'b0;
        end else begin
            if (instr_accept) begin
                instr_addr_q <= pc[ADDR_W-1:0];
            end
            if (data_accept) begin
                data_addr_q <= Data_addr[ADDR_W-1:0];
                data_rd_q   <= Data_rd;
            end
        end
    end

    // Output data registers, updated only on the completion edge of their channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_dout <= '0;
            Data_dout  <= '0;
        end else begin
            if (instr_respond) begin
                Instr_dout <= imem[instr_raddr];
            end
            if (data_respond && data_rd_eff) begin
                Data_dout <= dmem[data_raddr];
            end
        end
    end

    // Instruction memory is written only through the preload port.
    always_ff @(posedge clk) begin
        if (load_en && !load_sel) begin
            imem[load_addr] <= load_data;
        end
    end

    // Data memory: core writes land at acceptance; a same-edge preload overrides them.
    always_ff @(posedge clk) begin
        if (data_accept && !Data_rd) begin
            dmem[Data_addr[ADDR_W-1:0]] <= Data_din;
        end
        if (load_en && load_sel) begin
            dmem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: table-driven accesses scored
// against a queue of expected completions, plus hand-written corner sequences.
module tb_lc3_mem_responder;

    localparam int ADDR_W    = 8;
    localparam int INSTR_LAT = 1;
    localparam int DATA_LAT  = 2;
    localparam int LAT3      = 3;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit          is_data;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    logic              clk;
    logic              reset;
    logic [15:0]       pc;
    logic              instrmem_rd;
    logic [15:0]       Instr_dout;
    logic              complete_instr;
    logic [15:0]       Data_addr;
    logic              data_req;
    logic              Data_rd;
    logic [15:0]       Data_din;
    logic [15:0]       Data_dout;
    logic              complete_data;
    logic              load_en;
    logic              load_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              protocol_err;

    logic              data_req3;
    logic [15:0]       instr_dout3;
    logic              complete_instr3;
    logic [15:0]       data_dout3;
    logic              complete_data3;
    logic              protocol_err3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t iq[$];
    exp_t dq[$];
    exp_t dq3[$];
    exp_t ei, ed, ed3;
    vec_t vecs[7];

    lc3_mem_responder #(.ADDR_W(ADDR_W), .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .Data_addr      (Data_addr),
        .data_req       (data_req),
        .Data_rd        (Data_rd),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data),
        .load_en        (load_en),
        .load_sel       (load_sel),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .protocol_err   (protocol_err)
    );

    // Second instance with a longer data latency for the busy-violation sequence.
    lc3_mem_responder #(.ADDR_W(ADDR_W), .INSTR_LAT(INSTR_LAT), .DATA_LAT(LAT3)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (1'b0),
        .Instr_dout     (instr_dout3),
        .complete_instr (complete_instr3),
        .Data_addr      (Data_addr),
        .data_req       (data_req3),
        .Data_rd        (Data_rd),
        .Data_din       (Data_din),
        .Data_dout      (data_dout3),
        .complete_data  (complete_data3),
        .load_en        (load_en),
        .load_sel       (load_sel),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .protocol_err   (protocol_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_spurious(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s got complete=1 expected complete=0", name);
    endtask

    // Pops and scores every completion pulse against the expected queues.
    always @(negedge clk) begin
        if (reset) begin
            if (complete_instr) begin
                if (iq.size() == 0) flag_spurious("instr_spurious");
                else begin
                    ei = iq.pop_front();
                    check_output("instr_data", {16'h0, Instr_dout}, {16'h0, ei.data});
                    check_output("instr_latency", cyc, ei.due);
                end
            end
            if (complete_data) begin
                if (dq.size() == 0) flag_spurious("data_spurious");
                else begin
                    ed = dq.pop_front();
                    check_output("data_data", {16'h0, Data_dout}, {16'h0, ed.data});
                    check_output("data_latency", cyc, ed.due);
                end
            end
            if (complete_data3) begin
                if (dq3.size() == 0) flag_spurious("lat3_spurious");
                else begin
                    ed3 = dq3.pop_front();
                    check_output("lat3_data", {16'h0, data_dout3}, {16'h0, ed3.data});
                    check_output("lat3_latency", cyc, ed3.due);
                end
            end
            if (complete_instr3) flag_spurious("lat3_instr_spurious");
        end
    end

    task automatic preload(input bit sel, input logic [ADDR_W-1:0] addr, input logic [15:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        if (v.is_data) begin
            data_req  = 1'b1;
            Data_rd   = v.rd;
            Data_addr = v.addr;
            Data_din  = v.din;
            dq.push_back('{cyc + DATA_LAT, v.exp});
        end else begin
            instrmem_rd = 1'b1;
            pc          = v.addr;
            iq.push_back('{cyc + INSTR_LAT, v.exp});
        end
        @(negedge clk);
        data_req    = 1'b0;
        instrmem_rd = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((iq.size() != 0 || dq.size() != 0 || dq3.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (iq.size() != 0 || dq.size() != 0 || dq3.size() != 0) begin
            errors++;
            $display("[TB] FAIL wait_idle got pending=%0d expected pending=0",
                     iq.size() + dq.size() + dq3.size());
            iq.delete();
            dq.delete();
            dq3.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h3010, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 16'hFF30, 16'h0000, 16'hCAFE};
        vecs[4] = '{1'b0, 1'b1, 16'h7F01, 16'h0000, 16'h2222};
        vecs[5] = '{1'b1, 1'b0, 16'h0121, 16'h0042, 16'hCAFE};
        vecs[6] = '{1'b1, 1'b1, 16'h0021, 16'h0000, 16'h0042};

        reset       = 1'b0;
        pc          = '0;
        instrmem_rd = 1'b0;
        Data_addr   = '0;
        data_req    = 1'b0;
        data_req3   = 1'b0;
        Data_rd     = 1'b1;
        Data_din    = '0;
        load_en     = 1'b0;
        load_sel    = 1'b0;
        load_addr   = '0;
        load_data   = '0;

        repeat (2) @(negedge clk);
        check_output("reset_instr_dout", {16'h0, Instr_dout}, 32'h0);
        check_output("reset_data_dout", {16'h0, Data_dout}, 32'h0);
        check_output("reset_complete_instr", {31'h0, complete_instr}, 32'h0);
        check_output("reset_complete_data", {31'h0, complete_data}, 32'h0);
        check_output("reset_protocol_err", {31'h0, protocol_err}, 32'h0);
        reset = 1'b1;

        preload(1'b0, 8'h10, 16'h1234);
        preload(1'b0, 8'h00, 16'h1111);
        preload(1'b0, 8'h01, 16'h2222);
        preload(1'b0, 8'h02, 16'h3333);
        preload(1'b1, 8'h30, 16'hCAFE);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            wait_idle(20);
        end
        check_output("table_protocol_err", {31'h0, protocol_err}, 32'h0);

        // Back-to-back fetches with the strobe held: one completion per cycle.
        @(negedge clk);
        instrmem_rd = 1'b1;
        for (int a = 0; a < 3; a++) begin
            pc = 16'(a);
            iq.push_back('{cyc + INSTR_LAT, 16'(16'h1111 * (a + 1))});
            if (a < 2) @(negedge clk);
        end
        @(negedge clk);
        instrmem_rd = 1'b0;
        wait_idle(20);

        // Preload and core write on the same word at the same edge: preload wins.
        @(negedge clk);
        data_req  = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h0005;
        Data_din  = 16'h5555;
        load_en   = 1'b1;
        load_sel  = 1'b1;
        load_addr = 8'h05;
        load_data = 16'hAAAA;
        dq.push_back('{cyc + DATA_LAT, 16'h0042});
        @(negedge clk);
        data_req = 1'b0;
        load_en  = 1'b0;
        wait_idle(20);
        apply_stimulus('{1'b1, 1'b1, 16'h0005, 16'h0000, 16'hAAAA});
        wait_idle(20);

        // Busy violation on the three-edge data channel.
        @(negedge clk);
        data_req3 = 1'b1;
        Data_rd   = 1'b1;
        Data_addr = 16'h0030;
        dq3.push_back('{cyc + LAT3, 16'hCAFE});
        @(negedge clk);
        Data_addr = 16'h0010;
        @(negedge clk);
        data_req3 = 1'b0;
        check_output("lat3_err_set", {31'h0, protocol_err3}, 32'h1);
        wait_idle(20);
        repeat (5) @(negedge clk);
        check_output("lat3_err_sticky", {31'h0, protocol_err3}, 32'h1);
        check_output("main_err_clear", {31'h0, protocol_err}, 32'h0);

        // Reset while a data read has one edge left: the access is aborted.
        @(negedge clk);
        data_req  = 1'b1;
        Data_rd   = 1'b1;
        Data_addr = 16'h0030;
        @(negedge clk);
        data_req = 1'b0;
        reset    = 1'b0;
        #1;
        check_output("abort_data_dout", {16'h0, Data_dout}, 32'h0);
        check_output("abort_instr_dout", {16'h0, Instr_dout}, 32'h0);
        check_output("abort_lat3_err", {31'h0, protocol_err3}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_output("abort_complete_data", {31'h0, complete_data}, 32'h0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_output("post_reset_data_dout", {16'h0, Data_dout}, 32'h0);

        apply_stimulus('{1'b1, 1'b1, 16'h0030, 16'h0000, 16'hCAFE});
        wait_idle(20);
        apply_stimulus('{1'b1, 1'b1, 16'h0005, 16'h0000, 16'hAAAA});
        wait_idle(20);
        apply_stimulus('{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234});
        wait_idle(20);
        check_output("final_protocol_err", {31'h0, protocol_err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
